// File: rtl/ecc_lockstep_if.sv
// Bus bundle for the ECC lockstep checker: codeword input, mode controls,
// per-beat result and event-counter status.
interface ecc_lockstep_if #(
   parameter int DATA_WIDTH   = 69,
   parameter int PARITY_WIDTH = 8,
   parameter int CNT_WIDTH    = 8
);
   logic                    in_vld;
   logic [DATA_WIDTH-1:0]   data_in;
   logic [PARITY_WIDTH-1:0] parity_in;
   logic                    bypass;
   logic                    fault_detc_en;
   logic                    inject_en;
   logic                    clr;

   logic                    out_vld;
   logic [DATA_WIDTH-1:0]   data_out;
   logic                    sbit_err;
   logic                    dbit_err;
   logic                    ecc_fault;
   logic                    fault_sticky;
   logic [CNT_WIDTH-1:0]    fault_cnt;
   logic [CNT_WIDTH-1:0]    sbit_cnt;
   logic [CNT_WIDTH-1:0]    dbit_cnt;
   logic                    fault_irq;

   modport master (
      output in_vld, data_in, parity_in, bypass, fault_detc_en, inject_en, clr,
      input  out_vld, data_out, sbit_err, dbit_err, ecc_fault, fault_sticky,
             fault_cnt, sbit_cnt, dbit_cnt, fault_irq
   );

   modport slave (
      input  in_vld, data_in, parity_in, bypass, fault_detc_en, inject_en, clr,
      output out_vld, data_out, sbit_err, dbit_err, ecc_fault, fault_sticky,
             fault_cnt, sbit_cnt, dbit_cnt, fault_irq
   );
endinterface

// File: rtl/ecc_lockstep_checker.sv
// SECDED decode with two lockstep cores. Core A drives the result; any
// disagreement with core B (optionally provoked by inject_en) is a fault that
// falls back to raw data and is counted, made sticky and raised as an irq.
//
// Code layout: Hamming positions 1..N, check bit j at position 2^j
// (parity[j]), data bits fill the non-power-of-two positions in order, and
// parity[PARITY_WIDTH-1] is overall even parity over data and check bits.
module ecc_secded_dec #(
   parameter int DATA_WIDTH   = 69,
   parameter int PARITY_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0]   i_data,
   input  logic [PARITY_WIDTH-1:0] i_parity,
   input  logic                    i_bypass,
   output logic [DATA_WIDTH-1:0]   o_mask,
   output logic                    o_sbit,
   output logic                    o_dbit
);
   localparam int HW = PARITY_WIDTH - 1;

   // Hamming position of data bit idx: skip every power of two on the way up.
   function automatic logic [HW-1:0] f_pos(input int idx);
      int p;
      p = idx + 1;
      for (int j = 0; j < HW; j++)
         if ((1 << j) <= p) p++;
      return HW'(p);
   endfunction

   logic [HW-1:0] w_syn;
   logic          w_par;

   // Syndrome is the XOR of the positions of all set bits; overall parity over the whole word.
   always_comb begin
      w_syn = '0;
      for (int i = 0; i < DATA_WIDTH; i++)
         if (i_data[i]) w_syn = w_syn ^ f_pos(i);
      for (int j = 0; j < HW; j++)
         if (i_parity[j]) w_syn = w_syn ^ HW'(1 << j);
      w_par = ^{i_data, i_parity};
   end

   // Odd parity = single error (fix the data bit the syndrome names, if any);
   // even parity with a non-zero syndrome = double error, left uncorrected.
   always_comb begin
      o_mask = '0;
      o_sbit = 1'b0;
      o_dbit = 1'b0;
      if (!i_bypass) begin
         o_sbit = w_par;
         o_dbit = ~w_par & (w_syn != '0);
         for (int i = 0; i < DATA_WIDTH; i++)
            o_mask[i] = w_par & (w_syn == f_pos(i));
      end
   end
endmodule

module ecc_lockstep_checker #(
   parameter int DATA_WIDTH   = 69,
   parameter int PARITY_WIDTH = 8,
   parameter int CNT_WIDTH    = 8,
   parameter int FAULT_THRESH = 1
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   ecc_lockstep_if.slave  bus
);
   localparam logic [CNT_WIDTH-1:0] LP_THRESH = CNT_WIDTH'(FAULT_THRESH);

   function automatic logic [CNT_WIDTH-1:0] f_sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   logic [1:0][DATA_WIDTH-1:0] w_mask;
   logic [1:0]                 w_sbit;
   logic [1:0]                 w_dbit;
   logic [DATA_WIDTH-1:0]      w_mask_b;
   logic                       w_mismatch;
   logic                       w_beat_fault;
   logic                       w_sbit_ev;
   logic                       w_dbit_ev;
   logic                       w_irq_hit;
   logic [DATA_WIDTH-1:0]      w_data_sel;

   logic                       r_out_vld;
   logic [DATA_WIDTH-1:0]      r_data;
   logic                       r_sbit;
   logic                       r_dbit;
   logic                       r_fault;
   logic                       r_sticky;
   logic [CNT_WIDTH-1:0]       r_fault_cnt;
   logic [CNT_WIDTH-1:0]       r_sbit_cnt;
   logic [CNT_WIDTH-1:0]       r_dbit_cnt;
   logic                       r_irq;
   logic                       r_armed;

   // Core 0 is A (drives the result), core 1 is B (compare only). The
   // implementation flow must keep them as separate physical copies.
   for (genvar c = 0; c < 2; c++) begin : g_core
      ecc_secded_dec #(
         .DATA_WIDTH  (DATA_WIDTH),
         .PARITY_WIDTH(PARITY_WIDTH)
      ) u_dec (
         .i_data  (bus.data_in),
         .i_parity(bus.parity_in),
         .i_bypass(bus.bypass),
         .o_mask  (w_mask[c]),
         .o_sbit  (w_sbit[c]),
         .o_dbit  (w_dbit[c])
      );
   end

   // Self-test: flipping B's mask bit 0 forces a mismatch even in bypass.
   always_comb begin
      w_mask_b    = w_mask[1];
      w_mask_b[0] = w_mask[1][0] ^ bus.inject_en;
   end

   assign w_mismatch   = {w_sbit[0], w_dbit[0], w_mask[0]} != {w_sbit[1], w_dbit[1], w_mask_b};
   assign w_beat_fault = w_mismatch & bus.fault_detc_en & bus.in_vld;
   assign w_sbit_ev    = bus.in_vld & w_sbit[0];
   assign w_dbit_ev    = bus.in_vld & w_dbit[0];
   assign w_data_sel   = w_beat_fault ? bus.data_in : (bus.data_in ^ w_mask[0]);
   // irq fires only on the increment that lands exactly on the threshold.
   assign w_irq_hit    = w_beat_fault & (r_fault_cnt != '1) & ((r_fault_cnt + 1'b1) == LP_THRESH);

   // One-cycle result stage; data holds across idle cycles, flags do not.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_out_vld <= 1'b0;
         r_data    <= '0;
         r_sbit    <= 1'b0;
         r_dbit    <= 1'b0;
         r_fault   <= 1'b0;
      end else begin
         r_out_vld <= bus.in_vld;
         if (bus.in_vld) r_data <= w_data_sel;
         r_sbit    <= w_sbit_ev;
         r_dbit    <= w_dbit_ev;
         r_fault   <= w_beat_fault;
      end
   end

   // Event counters, sticky flag and one-shot irq; clr beats a same-cycle event.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || bus.clr) begin
         r_sticky    <= 1'b0;
         r_fault_cnt <= '0;
         r_sbit_cnt  <= '0;
         r_dbit_cnt  <= '0;
         r_irq       <= 1'b0;
         r_armed     <= 1'b1;
      end else begin
         if (w_beat_fault) begin
            r_sticky    <= 1'b1;
            r_fault_cnt <= f_sat_inc(r_fault_cnt);
         end
         if (w_sbit_ev) r_sbit_cnt <= f_sat_inc(r_sbit_cnt);
         if (w_dbit_ev) r_dbit_cnt <= f_sat_inc(r_dbit_cnt);
         r_irq <= r_armed & w_irq_hit;
         if (r_armed & w_irq_hit) r_armed <= 1'b0;
      end
   end

   assign bus.out_vld      = r_out_vld;
   assign bus.data_out     = r_data;
   assign bus.sbit_err     = r_sbit;
   assign bus.dbit_err     = r_dbit;
   assign bus.ecc_fault    = r_fault;
   assign bus.fault_sticky = r_sticky;
   assign bus.fault_cnt    = r_fault_cnt;
   assign bus.sbit_cnt     = r_sbit_cnt;
   assign bus.dbit_cnt     = r_dbit_cnt;
   assign bus.fault_irq    = r_irq;
endmodule

// File: tb/tb_ecc_lockstep_checker.sv
// Scoreboard bench: the driver builds clean codewords, plants a known number
// of bit flips, predicts the next-cycle outputs from that knowledge and
// queues them; a monitor pops and compares one entry per clock.
module tb_ecc_lockstep_checker;
   localparam int DW   = 69;
   localparam int PW   = 8;
   localparam int HW   = PW - 1;
   localparam int CW   = 2;
   localparam int TH   = 2;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct {
      logic          vld;
      logic [DW-1:0] data;
      logic          sbit, dbit, fault, sticky, irq;
      int            fcnt, scnt, dcnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ecc_lockstep_if #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(CW)) bus();

   ecc_lockstep_checker #(
      .DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(CW), .FAULT_THRESH(TH)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   exp_t          sb[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            pos_of[DW];

   logic [DW-1:0] m_data   = '0;
   int            m_fcnt   = 0, m_scnt = 0, m_dcnt = 0;
   bit            m_sticky = 0, m_armed = 1;

   // Data bit i sits at the i-th Hamming position that is not a power of two.
   function automatic void build_pos();
      int n = 0;
      for (int q = 1; n < DW; q++)
         if ((q & (q - 1)) != 0) begin
            pos_of[n] = q;
            n++;
         end
   endfunction

   function automatic logic [PW-1:0] encode(input logic [DW-1:0] d);
      int s = 0;
      logic [PW-1:0] p;
      for (int i = 0; i < DW; i++)
         if (d[i]) s = s ^ pos_of[i];
      p = '0;
      p[HW-1:0] = HW'(s);
      p[PW-1]   = (^d) ^ (^p[HW-1:0]);
      return p;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // rn = rst_n value; nfl = number of flipped codeword bits; fbit = forced first flip (-1 random).
   task automatic drive(input bit rn, vld, byp, det, inj, clr, input int nfl, input int fbit);
      logic [DW-1:0]    d;
      logic [PW-1:0]    p;
      logic [DW+PW-1:0] cw;
      int               a, b;
      bit               bf;
      exp_t             e;
      @(negedge clk);
      d  = DW'({$urandom, $urandom, $urandom});
      p  = encode(d);
      cw = {p, d};
      a  = (fbit >= 0) ? fbit : int'($urandom_range(DW + PW - 1));
      if (nfl >= 1) cw[a] = ~cw[a];
      if (nfl == 2) begin
         do b = int'($urandom_range(DW + PW - 1)); while (b == a);
         cw[b] = ~cw[b];
      end
      rst_n             = rn;
      bus.in_vld        = vld;
      bus.data_in       = cw[DW-1:0];
      bus.parity_in     = cw[DW+PW-1:DW];
      bus.bypass        = byp;
      bus.fault_detc_en = det;
      bus.inject_en     = inj;
      bus.clr           = clr;

      bf    = vld && inj && det;
      e.irq = 1'b0;
      if (!rn) begin
         m_data = '0; m_fcnt = 0; m_scnt = 0; m_dcnt = 0; m_sticky = 0; m_armed = 1;
         e.vld = 0; e.sbit = 0; e.dbit = 0; e.fault = 0;
      end else begin
         e.vld   = vld;
         e.sbit  = vld && !byp && (nfl == 1);
         e.dbit  = vld && !byp && (nfl == 2);
         e.fault = bf;
         // Only a corrected single error (or clean word) yields the original data.
         if (vld) m_data = (bf || byp || nfl == 2) ? cw[DW-1:0] : d;
         if (clr) begin
            m_fcnt = 0; m_scnt = 0; m_dcnt = 0; m_sticky = 0; m_armed = 1;
         end else begin
            if (bf) begin
               m_sticky = 1;
               if (m_fcnt < CMAX) begin
                  m_fcnt++;
                  if (m_fcnt == TH && m_armed) begin
                     e.irq   = 1'b1;
                     m_armed = 0;
                  end
               end
            end
            if (e.sbit && m_scnt < CMAX) m_scnt++;
            if (e.dbit && m_dcnt < CMAX) m_dcnt++;
         end
      end
      e.data = m_data; e.sticky = m_sticky;
      e.fcnt = m_fcnt; e.scnt = m_scnt; e.dcnt = m_dcnt;
      sb.push_back(e);
   endtask

   // Monitor: one expected entry per clock, checked just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_vld",      128'(bus.out_vld),      128'(e.vld));
            chk("data_out",     128'(bus.data_out),     128'(e.data));
            chk("sbit_err",     128'(bus.sbit_err),     128'(e.sbit));
            chk("dbit_err",     128'(bus.dbit_err),     128'(e.dbit));
            chk("ecc_fault",    128'(bus.ecc_fault),    128'(e.fault));
            chk("fault_sticky", 128'(bus.fault_sticky), 128'(e.sticky));
            chk("fault_cnt",    128'(bus.fault_cnt),    128'(e.fcnt));
            chk("sbit_cnt",     128'(bus.sbit_cnt),     128'(e.scnt));
            chk("dbit_cnt",     128'(bus.dbit_cnt),     128'(e.dcnt));
            chk("fault_irq",    128'(bus.fault_irq),    128'(e.irq));
         end
      end
   end

   initial begin
      build_pos();
      bus.in_vld = 0; bus.data_in = '0; bus.parity_in = '0;
      bus.bypass = 0; bus.fault_detc_en = 0; bus.inject_en = 0; bus.clr = 0;

      // Held in reset, even with valid input.
      drive(0, 1, 0, 1, 0, 0, 0, -1);
      drive(0, 0, 0, 1, 0, 0, 0, -1);
      // Clean word, then data bit 5 flipped.
      drive(1, 1, 0, 1, 0, 0, 0, -1);
      drive(1, 1, 0, 1, 0, 0, 1, 5);
      // Idle cycle: data holds, flags drop.
      drive(1, 0, 0, 1, 0, 0, 1, -1);
      // Two injected faults on single-bit errors: irq on the second.
      drive(1, 0, 0, 1, 0, 1, 0, -1);
      drive(1, 1, 0, 1, 1, 0, 1, -1);
      drive(1, 1, 0, 1, 1, 0, 1, -1);
      // Injection with compare disabled: no fault, corrected data.
      drive(1, 1, 0, 0, 1, 0, 1, -1);
      // Saturation at 3, then clr beating a same-cycle fault.
      for (int i = 0; i < 5; i++) drive(1, 1, 0, 1, 1, 0, 0, -1);
      drive(1, 1, 0, 1, 1, 1, 0, -1);
      // Double errors, parity-bit errors, bypass with and without injection.
      drive(1, 1, 0, 1, 0, 0, 2, -1);
      drive(1, 1, 0, 1, 0, 0, 1, DW + PW - 1);
      drive(1, 1, 0, 1, 0, 0, 1, DW);
      drive(1, 1, 1, 1, 0, 0, 1, 0);
      drive(1, 1, 1, 1, 1, 0, 2, -1);
      // Reset for one cycle mid-stream.
      drive(1, 1, 0, 1, 1, 0, 1, -1);
      drive(0, 1, 0, 1, 1, 0, 1, -1);
      drive(1, 1, 0, 1, 1, 0, 1, -1);
      drive(1, 1, 0, 1, 0, 0, 0, -1);

      for (int i = 0; i < 600; i++)
         drive($urandom_range(49) != 0, $urandom_range(3) != 0, $urandom_range(7) == 0,
               $urandom_range(1) == 1, $urandom_range(3) == 0, $urandom_range(15) == 0,
               int'($urandom_range(2)), -1);

      repeat (3) @(posedge clk);
      #2;
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
